bram_bank_xlat_pipe: RTL and testbench
======================================

Name: bram_bank_xlat_pipe

Overview:
- Pipelined successor to the combinational single-port-to-multi-bank BRAM translator.
- Maps one wide BRAM-controller port (IN_WORD_DATA data per word, packed lsb to msb) onto BANKS single-datum banks using low-order interleaving.
- Adds an optional request register and a tracked bank read latency, so read data is steered with the bank select that was in force when the read was issued, not the current one.
- Adds a read-valid strobe. Sits between the AXI BRAM controller and the multi-bank weight/activation memories.

Parameters:
- IN_WIDTH, 32, input word width.
- OUT_WIDTH, 16, bank datum width; must be a multiple of 8.
- BANKS, 4, number of banks; power of 2.
- IN_WORD_DATA, IN_WIDTH/OUT_WIDTH, data per input word; power of 2, must divide BANKS.
- OUT_DEPTH, 256, words per bank.
- RD_LATENCY, 1, bank read latency in cycles; range 1..4.
- IN_REG, 1, 1 = register requests before they reach the banks; 0 = pass requests combinationally.
- OUT_ADDR, LOG2(OUT_DEPTH), bank address bits.
- OUT_WE, OUT_WIDTH/8, bank byte enables.
- GROUPS, BANKS/IN_WORD_DATA, number of bank groups (derived).
- IN_ADDR, LOG2(GROUPS*OUT_DEPTH), input word address bits.
- IN_WE, IN_WIDTH/8, input byte enables.

Ports:
- clk, in, 1, clock.
- resetn, in, 1, reset; asynchronous assert, active-low.
- en_i, in, 1, request strobe.
- we_i, in, IN_WE, byte write enables; any bit set makes the request a write.
- addr_i, in, IN_ADDR, input word address.
- wrdata_i, in, IN_WIDTH, write word.
- rddata_i, out, IN_WIDTH, assembled read word.
- rdvalid_i, out, 1, one-cycle strobe marking rddata_i valid.
- en_o, out, BANKS, per-bank enable.
- we_o, out, BANKS*OUT_WE, per-bank byte enables.
- addr_o, out, BANKS*OUT_ADDR, per-bank address.
- wrdata_o, out, BANKS*OUT_WIDTH, per-bank write data.
- rddata_o, in, BANKS*OUT_WIDTH, per-bank read data.

Behaviour:
- Mapping:
  - g = addr_i mod GROUPS.
  - Datum j of the word (j = 0..IN_WORD_DATA-1) maps to bank g*IN_WORD_DATA+j at bank address addr_i / GROUPS.
  - Equivalent to global datum d = addr_i*IN_WORD_DATA+j with bank = d mod BANKS.
- Bank outputs:
  - addr_o is broadcast to all banks.
  - wrdata_o slice of bank b = wrdata_i datum (b mod IN_WORD_DATA).
  - en_o is set only for the IN_WORD_DATA banks of group g, and only when en_i=1.
  - we_o for bank b = the OUT_WE slice of we_i for datum (b mod IN_WORD_DATA), gated by en_o[b].
- Issue latency:
  - IN_REG=1: bank signals appear 1 cycle after en_i is sampled.
  - IN_REG=0: bank signals are combinational from the inputs.
  - Throughput is one request per cycle; there is no stall.
- Read tracking:
  - A read is en_i=1 with we_i=0.
  - A shift register of RD_LATENCY stages carries {valid, g} from the cycle the read reaches the banks.
  - At the last stage: rdvalid_i=1 for 1 cycle, and rddata_i is registered from the rddata_o slices of the stored group's banks, datum j taken from bank g*IN_WORD_DATA+j.
  - Total read latency = IN_REG + RD_LATENCY + 1 cycles from en_i.
- rddata_i holds its value until the next rdvalid_i.
- Writes never raise rdvalid_i.
- A write directly after a read does not disturb the in-flight read; back-to-back reads to different groups return in order.
- Reset (async, resetn=0):
  - en_o, we_o, addr_o, wrdata_o, rddata_i, rdvalid_i all 0.
  - Tracking pipeline cleared.
  - Reads in flight are dropped and produce no rdvalid_i after release.
- Illegal parameter combinations (non-power-of-2 BANKS or IN_WORD_DATA, IN_WORD_DATA > BANKS, OUT_WIDTH not a multiple of 8) fail elaboration.

Optional Feature:
- Macro BRAM_XLAT_PERF_EN.
- Defined: adds output ports rd_cnt_o [31:0] and wr_cnt_o [31:0].
  - Each counts accepted reads / writes at issue.
  - Saturating at 0xFFFFFFFF.
  - Cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write, defaults, IN_REG=1: en_i=1, we_i=4'hF, addr_i=5, wrdata_i=0xBEEF1234 -> next cycle en_o=4'b1100, we_o banks 2,3=2'b11, banks 0,1=0, addr_o=2 for all banks, bank2 data=0x1234, bank3 data=0xBEEF.
- Partial write: we_i=4'b0100, addr_i=0 -> en_o=4'b0011, only bank1 we_o=2'b01.
- Read latency, RD_LATENCY=2: read addr_i=5 at cycle 0 with bank model returning 0x1234/0xBEEF -> rdvalid_i exactly at cycle 4, rddata_i=0xBEEF1234, held afterwards.
- Back-to-back reads: addr_i=4 then 5 on consecutive cycles -> two consecutive rdvalid_i pulses carrying group 0 data then group 1 data, no cross-steering.
- Reset mid-flight: read issued, resetn=0 one cycle later -> all outputs 0 immediately; no rdvalid_i after release.
- With BRAM_XLAT_PERF_EN: 3 reads + 2 writes -> rd_cnt_o=3, wr_cnt_o=2; counter forced to 0xFFFFFFFF stays saturated after a further read.

Source files
------------

// File: rtl/bram_bank_xlat_pipe.sv
// bram_bank_xlat_pipe: pipelined wide-port to interleaved multi-bank BRAM translator with tracked read return.
// Optional macro BRAM_XLAT_PERF_EN adds saturating read/write request counters (rd_cnt_o, wr_cnt_o).
module bram_bank_xlat_pipe #(
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int BANKS        = 4,
    parameter int IN_WORD_DATA = IN_WIDTH / OUT_WIDTH,
    parameter int OUT_DEPTH    = 256,
    parameter int RD_LATENCY   = 1,
    parameter int IN_REG       = 1,
    parameter int OUT_ADDR     = $clog2(OUT_DEPTH),
    parameter int OUT_WE       = OUT_WIDTH / 8,
    parameter int GROUPS       = BANKS / IN_WORD_DATA,
    parameter int IN_ADDR      = $clog2(GROUPS * OUT_DEPTH),
    parameter int IN_WE        = IN_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          resetn,
`ifdef BRAM_XLAT_PERF_EN
    output logic [31:0]                   rd_cnt_o,
    output logic [31:0]                   wr_cnt_o,
`endif
    input  logic                          en_i,
    input  logic [IN_WE-1:0]              we_i,
    input  logic [IN_ADDR-1:0]            addr_i,
    input  logic [IN_WIDTH-1:0]           wrdata_i,
    output logic [IN_WIDTH-1:0]           rddata_i,
    output logic                          rdvalid_i,
    output logic [BANKS-1:0]              en_o,
    output logic [BANKS*OUT_WE-1:0]       we_o,
    output logic [BANKS*OUT_ADDR-1:0]     addr_o,
    output logic [BANKS*OUT_WIDTH-1:0]    wrdata_o,
    input  logic [BANKS*OUT_WIDTH-1:0]    rddata_o
);
    localparam int IWD = IN_WORD_DATA;
    localparam int GW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (BANKS < 1 || (BANKS & (BANKS - 1)) != 0 || IWD < 1 || (IWD & (IWD - 1)) != 0 ||
        IWD > BANKS || OUT_WIDTH % 8 != 0 || IN_WIDTH != IWD * OUT_WIDTH ||
        RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_params
        $error("bram_bank_xlat_pipe: illegal parameter combination");
    end

    logic                  w_req_en;
    logic [IN_WE-1:0]      w_req_we;
    logic [IN_ADDR-1:0]    w_req_addr;
    logic [IN_WIDTH-1:0]   w_req_wd;
    logic [GW-1:0]         w_g;
    logic [OUT_ADDR-1:0]   w_baddr;
    logic                  w_rd;
    logic [IN_WIDTH-1:0]   w_rd_word;
    logic [RD_LATENCY-1:0] r_vld;
    logic [GW-1:0]         r_grp [RD_LATENCY];
    logic                  r_rdvalid;
    logic [IN_WIDTH-1:0]   r_rddata;

    if (IN_REG != 0) begin : g_in_reg
        logic                r_en;
        logic [IN_WE-1:0]    r_we;
        logic [IN_ADDR-1:0]  r_addr;
        logic [IN_WIDTH-1:0] r_wd;
        // Register the request so the banks see it one cycle after it is sampled.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_en   <= 1'b0;
                r_we   <= '0;
                r_addr <= '0;
                r_wd   <= '0;
            end else begin
                r_en   <= en_i;
                r_we   <= we_i;
                r_addr <= addr_i;
                r_wd   <= wrdata_i;
            end
        end
        assign w_req_en   = r_en;
        assign w_req_we   = r_we;
        assign w_req_addr = r_addr;
        assign w_req_wd   = r_wd;
    end else begin : g_in_comb
        // Combinational path still forces all bank signals low while reset is held.
        assign w_req_en   = resetn & en_i;
        assign w_req_we   = resetn ? we_i : '0;
        assign w_req_addr = resetn ? addr_i : '0;
        assign w_req_wd   = resetn ? wrdata_i : '0;
    end

    assign w_g     = GW'(w_req_addr % IN_ADDR'(GROUPS));
    assign w_baddr = OUT_ADDR'(w_req_addr / IN_ADDR'(GROUPS));
    assign w_rd    = w_req_en && !(|w_req_we);

    // Steer the request onto the banks of its group; address and data are broadcast.
    always_comb begin
        en_o     = '0;
        we_o     = '0;
        addr_o   = '0;
        wrdata_o = '0;
        for (int b = 0; b < BANKS; b++) begin
            en_o[b]                            = w_req_en && (b / IWD == int'(w_g));
            we_o[b*OUT_WE +: OUT_WE]           = (w_req_en && (b / IWD == int'(w_g))) ?
                                                 w_req_we[(b % IWD)*OUT_WE +: OUT_WE] : '0;
            addr_o[b*OUT_ADDR +: OUT_ADDR]     = w_baddr;
            wrdata_o[b*OUT_WIDTH +: OUT_WIDTH] = w_req_wd[(b % IWD)*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Carry each read's group alongside the bank latency so data is steered by its own group.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) r_grp[k] <= '0;
        end else begin
            r_vld[0] <= w_rd;
            r_grp[0] <= w_g;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_grp[k] <= r_grp[k-1];
            end
        end
    end

    // Gather the returning datums from the banks of the stored group.
    always_comb begin
        w_rd_word = '0;
        for (int j = 0; j < IWD; j++)
            w_rd_word[j*OUT_WIDTH +: OUT_WIDTH] =
                rddata_o[(int'(r_grp[RD_LATENCY-1])*IWD + j)*OUT_WIDTH +: OUT_WIDTH];
    end

    // Register the assembled word and hold it until the next returning read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdvalid <= 1'b0;
            r_rddata  <= '0;
        end else begin
            r_rdvalid <= r_vld[RD_LATENCY-1];
            if (r_vld[RD_LATENCY-1]) r_rddata <= w_rd_word;
        end
    end

    assign rdvalid_i = r_rdvalid;
    assign rddata_i  = r_rddata;

`ifdef BRAM_XLAT_PERF_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    // Count requests as they are issued to the banks, saturating at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_req_en && |w_req_we && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end
    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_bram_bank_xlat_pipe.sv
// tb_bram_bank_xlat_pipe: directed and random checks of bram_bank_xlat_pipe against a flat datum-memory model.
module tb_bram_bank_xlat_pipe;
    localparam int IW = 32, OW = 16, NB = 4, IWD = 2, DEPTH = 256, L = 2;
    localparam int GR = NB / IWD, OA = 8, IA = 9, OWE = 2, IWE = 4;
    localparam int LAT = 1 + L + 1;

    logic                clk = 1'b0;
    logic                resetn;
    logic                en_i;
    logic [IWE-1:0]      we_i;
    logic [IA-1:0]       addr_i;
    logic [IW-1:0]       wrdata_i;
    logic [IW-1:0]       rddata_i;
    logic                rdvalid_i;
    logic [NB-1:0]       en_o;
    logic [NB*OWE-1:0]   we_o;
    logic [NB*OA-1:0]    addr_o;
    logic [NB*OW-1:0]    wrdata_o;
    logic [NB*OW-1:0]    rddata_o;
`ifdef BRAM_XLAT_PERF_EN
    logic [31:0]         rd_cnt_o;
    logic [31:0]         wr_cnt_o;
`endif

    bram_bank_xlat_pipe #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .BANKS(NB), .OUT_DEPTH(DEPTH),
        .RD_LATENCY(L), .IN_REG(1)
    ) dut (
        .clk(clk), .resetn(resetn),
`ifdef BRAM_XLAT_PERF_EN
        .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o),
`endif
        .en_i(en_i), .we_i(we_i), .addr_i(addr_i), .wrdata_i(wrdata_i),
        .rddata_i(rddata_i), .rdvalid_i(rdvalid_i),
        .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .wrdata_o(wrdata_o), .rddata_o(rddata_o)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] ref_mem [NB*DEPTH];
    logic [OW-1:0] bmem    [NB][DEPTH];
    logic [OW-1:0] bpipe   [NB][L];

    function automatic logic [OW-1:0] merge(input logic [OW-1:0] old_v, input logic [OW-1:0] new_v,
                                            input logic [OWE-1:0] be);
        logic [OW-1:0] r;
        r = old_v;
        for (int k = 0; k < OWE; k++) if (be[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            for (int d = 0; d < NB*DEPTH; d++) bmem[d % NB][d / NB] <= ref_mem[d];
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (en_o[b] && |we_o[b*OWE +: OWE])
                    bmem[b][addr_o[b*OA +: OA]] <= merge(bmem[b][addr_o[b*OA +: OA]],
                                                         wrdata_o[b*OW +: OW], we_o[b*OWE +: OWE]);
                if (en_o[b] && !(|we_o[b*OWE +: OWE]))
                    bpipe[b][0] <= bmem[b][addr_o[b*OA +: OA]];
                for (int k = 1; k < L; k++) bpipe[b][k] <= bpipe[b][k-1];
            end
        end
    end

    always_comb begin
        rddata_o = '0;
        for (int b = 0; b < NB; b++) rddata_o[b*OW +: OW] = bpipe[b][L-1];
    end

    typedef struct { int due; logic [IW-1:0] data; } exp_t;
    exp_t q[$];
    int total = 0, passed = 0, fails = 0, cyc = 0;
    int n_rd = 0, n_wr = 0;
    logic [IW-1:0] last_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_ret();
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rdvalid_pulse", 64'(rdvalid_i), 64'd1);
            chk("rddata", 64'(rddata_i), 64'(q[0].data));
            last_rd = q[0].data;
            q.pop_front();
        end else begin
            chk("rdvalid_idle", 64'(rdvalid_i), 64'd0);
            chk("rddata_hold", 64'(rddata_i), 64'(last_rd));
        end
    endtask

    task automatic step(input logic en, input logic [IWE-1:0] we, input logic [IA-1:0] addr,
                        input logic [IW-1:0] wd);
        logic [NB-1:0]     x_en;
        logic [NB*OWE-1:0] x_we;
        logic [NB*OW-1:0]  x_wd;
        logic [IW-1:0]     word;
        int                d, ba;
        en_i = en; we_i = we; addr_i = addr; wrdata_i = wd;
        x_en = '0; x_we = '0; ba = 0; word = '0;
        for (int j = 0; j < IWD; j++) begin
            d  = int'(addr) * IWD + j;
            ba = d / NB;
            x_en[d % NB] = en;
            x_we[(d % NB)*OWE +: OWE] = en ? we[j*OWE +: OWE] : '0;
            word[j*OW +: OW] = ref_mem[d];
        end
        for (int b = 0; b < NB; b++) x_wd[b*OW +: OW] = wd[(b % IWD)*OW +: OW];
        if (en && we == '0) begin
            q.push_back('{cyc + LAT, word});
            n_rd++;
        end else if (en) begin
            for (int k = 0; k < IWE; k++)
                if (we[k]) ref_mem[int'(addr)*IWD + k/OWE][(k % OWE)*8 +: 8] = wd[k*8 +: 8];
            n_wr++;
        end
        @(posedge clk); #1; cyc++;
        chk("en_o", 64'(en_o), 64'(x_en));
        chk("we_o", 64'(we_o), 64'(x_we));
        chk("addr_o", 64'(addr_o), 64'({NB{OA'(ba)}}));
        chk("wrdata_o", 64'(wrdata_o), 64'(x_wd));
        check_ret();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; en_i = 1'b0; we_i = '0; addr_i = '0; wrdata_i = '0;
        for (int d = 0; d < NB*DEPTH; d++) ref_mem[d] = OW'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en_o", 64'(en_o), 64'd0);
        chk("rst_we_o", 64'(we_o), 64'd0);
        chk("rst_addr_o", 64'(addr_o), 64'd0);
        chk("rst_wrdata_o", 64'(wrdata_o), 64'd0);
        chk("rst_rddata", 64'(rddata_i), 64'd0);
        chk("rst_rdvalid", 64'(rdvalid_i), 64'd0);
        resetn = 1'b1;

        step(1'b1, 4'hF, 9'd5, 32'hBEEF1234);
        chk("wr_en_o", 64'(en_o), 64'h0C);
        chk("wr_we_o", 64'(we_o), 64'hF0);
        chk("wr_addr_o", 64'(addr_o), 64'h02020202);
        chk("wr_bank2", 64'(wrdata_o[47:32]), 64'h1234);
        chk("wr_bank3", 64'(wrdata_o[63:48]), 64'hBEEF);

        step(1'b1, 4'b0100, 9'd0, 32'h5A5A_A5A5);
        chk("pw_en_o", 64'(en_o), 64'h03);
        chk("pw_we_o", 64'(we_o), 64'h04);

        step(1'b1, 4'h0, 9'd5, 32'h0);
        repeat (3) step(1'b0, 4'h0, 9'd0, 32'h0);
        chk("lat_rdvalid", 64'(rdvalid_i), 64'd1);
        chk("lat_rddata", 64'(rddata_i), 64'hBEEF1234);
        repeat (2) step(1'b0, 4'h0, 9'd0, 32'h0);
        chk("lat_hold", 64'(rddata_i), 64'hBEEF1234);

        step(1'b1, 4'hF, 9'd4, 32'hCAFE0042);
        step(1'b1, 4'h0, 9'd4, 32'h0);
        step(1'b1, 4'h0, 9'd5, 32'h0);
        repeat (2) step(1'b0, 4'h0, 9'd0, 32'h0);
        chk("b2b_first", 64'({rdvalid_i, rddata_i}), 64'h1_CAFE0042);
        step(1'b0, 4'h0, 9'd0, 32'h0);
        chk("b2b_second", 64'({rdvalid_i, rddata_i}), 64'h1_BEEF1234);
        repeat (3) step(1'b0, 4'h0, 9'd0, 32'h0);

        step(1'b1, 4'h0, 9'd7, 32'h0);
        en_i = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_en_o", 64'(en_o), 64'd0);
        chk("mid_rst_we_o", 64'(we_o), 64'd0);
        chk("mid_rst_addr_o", 64'(addr_o), 64'd0);
        chk("mid_rst_wrdata_o", 64'(wrdata_o), 64'd0);
        chk("mid_rst_rd", 64'({rdvalid_i, rddata_i}), 64'd0);
        q.delete();
        last_rd = '0; n_rd = 0; n_wr = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (6) step(1'b0, 4'h0, 9'd0, 32'h0);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : IWE'($urandom),
                 IA'($urandom_range(0, GR*DEPTH - 1)), $urandom);
        repeat (LAT + 2) step(1'b0, 4'h0, 9'd0, 32'h0);
        chk("drain", 64'(q.size()), 64'd0);

`ifdef BRAM_XLAT_PERF_EN
        chk("rd_cnt", 64'(rd_cnt_o), 64'(n_rd));
        chk("wr_cnt", 64'(wr_cnt_o), 64'(n_wr));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
